uart_tx_stream: RTL and testbench

UART_TX_STREAM -- requirements
Module: uart_tx_stream

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_tx_stream.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_stream.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the streaming UART transmitter.
//   parity_e   : parity mode selector for the transmitter
//   tx_state_e : transmitter FSM state encoding
//   baud_div   : rounded clock cycles per line bit
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  // Round to nearest so that the bit period error stays within half a cycle.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered status flags.
//   clk     : clock, rising edge
//   rst     : synchronous reset, active-low
//   push_i  : write wdata_i (ignored while full_o)
//   pop_i   : consume the head word (ignored while empty_o)
//   wdata_i : word to store
//   rdata_o : head word, valid while empty_o is 0
//   full_o  : DEPTH words held
//   empty_o : no words held
//   level_o : current occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Qualify against the registered flags so a push into a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  assign level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-fed UART transmitter.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-low
//   push_back : queue data_in
//   data_in   : word to queue
//   full      : FIFO holds DEPTH words
//   empty     : FIFO holds no words
//   level     : FIFO occupancy
//   tx        : serial line, idle high
//   busy      : a frame is on the line
//   error     : sticky overflow (push while full)
//
// state    | meaning
// ---------+--------------------------------------------
// S_IDLE   | line idle, waiting for a queued word
// S_START  | start bit (0)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (never entered for PAR_NONE)
// S_STOP   | stop bit(s) (1)
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ  = 12_000_000,
  parameter int      BAUD      = 9_600,
  parameter int      DATA_BITS = 8,
  parameter int      DEPTH     = 16,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_back,
  input  logic [DATA_BITS-1:0]   data_in,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tx,
  output logic                   busy,
  output logic                   error
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP  = (STOP_BITS == 2);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 error_q;
  logic                 pop;
  logic                 bit_done;
  logic [DATA_BITS-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_back),
    .pop_i   (pop),
    .wdata_i (data_in),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign bit_done = (baud_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // The pop is issued where a frame is launched, so the end of the last
  // stop bit chains straight into the next start bit.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done && bit_cnt_q == LAST_DATA)
          state_d = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
      end
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_done && stop_cnt_q == LAST_STOP) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != S_IDLE);
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  // tx and busy are registered, so the line trails the state by one cycle
  // uniformly and every bit still lasts exactly DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
    end else if (pop) begin
      shift_q    <= fifo_rdata;
      parity_q   <= (PARITY == PAR_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);
      baud_cnt_q <= CNT_RELOAD;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else if (state_q != S_IDLE) begin
      if (bit_done) begin
        baud_cnt_q <= CNT_RELOAD;
        if (state_q == S_DATA) begin
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        if (state_q == S_STOP) stop_cnt_q <= stop_cnt_q + 1'b1;
      end else begin
        baud_cnt_q <= baud_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                   error_q <= 1'b0;
    else if (push_back && full) error_q <= 1'b1;
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign error = error_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;
  import uart_pkg::*;

  localparam int CLK_FREQ = 12_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] push;
  logic [7:0] din0, din3;
  logic [6:0] din1, din2;

  wire [3:0] tx_v, busy_v, full_v, empty_v, err_v;
  wire [2:0] lvl0;
  wire [4:0] lvl1, lvl2, lvl3;
  logic [4:0] lvl_v [4];

  assign lvl_v[0] = {2'b00, lvl0};
  assign lvl_v[1] = lvl1;
  assign lvl_v[2] = lvl2;
  assign lvl_v[3] = lvl3;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // 8N1, shallow FIFO: single, back-to-back, overflow and reset cases
  uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .DEPTH(4),
                   .PARITY(PAR_NONE), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .push_back(push[0]), .data_in(din0),
    .full(full_v[0]), .empty(empty_v[0]), .level(lvl0),
    .tx(tx_v[0]), .busy(busy_v[0]), .error(err_v[0]));

  // 7E1
  uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .DEPTH(16),
                   .PARITY(PAR_EVEN), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .push_back(push[1]), .data_in(din1),
    .full(full_v[1]), .empty(empty_v[1]), .level(lvl1),
    .tx(tx_v[1]), .busy(busy_v[1]), .error(err_v[1]));

  // 7O1
  uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .DEPTH(16),
                   .PARITY(PAR_ODD), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .push_back(push[2]), .data_in(din2),
    .full(full_v[2]), .empty(empty_v[2]), .level(lvl2),
    .tx(tx_v[2]), .busy(busy_v[2]), .error(err_v[2]));

  // 8N2
  uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .DEPTH(16),
                   .PARITY(PAR_NONE), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .push_back(push[3]), .data_in(din3),
    .full(full_v[3]), .empty(empty_v[3]), .level(lvl3),
    .tx(tx_v[3]), .busy(busy_v[3]), .error(err_v[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int idx, input logic [8:0] w);
    case (idx)
      0: din0 = w[7:0];
      1: din1 = w[6:0];
      2: din2 = w[6:0];
      default: din3 = w[7:0];
    endcase
    push[idx] = 1'b1;
    tick();
    push[idx] = 1'b0;
  endtask

  task automatic wait_start(input int idx);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_v[idx] === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk($sformatf("start_seen[%0d]", idx), {31'b0, found}, 32'd1);
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits.
  // par: 0 none, 1 odd, 2 even. Called at the first start-bit sample.
  task automatic check_frame(input int idx, input int word, input int nbits,
                             input int par, input int stops, input int exp_level);
    int bits [16];
    int nb   = 0;
    int ones = 0;
    bits[nb++] = 0;
    for (int k = 0; k < nbits; k++) begin
      bits[nb++] = (word >> k) & 1;
      ones += (word >> k) & 1;
    end
    if (par == 2) bits[nb++] = ones % 2;
    if (par == 1) bits[nb++] = 1 - (ones % 2);
    for (int k = 0; k < stops; k++) bits[nb++] = 1;
    chk($sformatf("level_at_start[%0d] w=%0h", idx, word), {27'b0, lvl_v[idx]}, exp_level);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("tx[%0d] w=%0h bit%0d cyc%0d", idx, word, b, c),
            {31'b0, tx_v[idx]}, bits[b]);
        chk($sformatf("busy[%0d] w=%0h bit%0d", idx, word, b), {31'b0, busy_v[idx]}, 32'd1);
        tick();
      end
    end
  endtask

  task automatic check_idle(input int idx, input int cycles);
    bit bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0) bad = 1'b1;
      tick();
    end
    chk($sformatf("stays_idle[%0d]", idx), {31'b0, bad}, 32'd0);
  endtask

  initial begin
    int q [$];
    int w;
    rst  = 1'b0;
    push = 4'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    tick(); tick();

    // reset state
    chk("rst_tx", {31'b0, tx_v[0]}, 32'd1);
    chk("rst_busy", {31'b0, busy_v[0]}, 32'd0);
    chk("rst_empty", {31'b0, empty_v[0]}, 32'd1);
    chk("rst_full", {31'b0, full_v[0]}, 32'd0);
    chk("rst_level", {27'b0, lvl_v[0]}, 32'd0);
    chk("rst_error", {31'b0, err_v[0]}, 32'd0);
    rst = 1'b1;
    tick();

    // single word 0xA5: tx falls exactly two cycles after the push edge
    push_word(0, 9'h0A5);
    chk("single_level_after_push", {27'b0, lvl_v[0]}, 32'd1);
    chk("single_empty_after_push", {31'b0, empty_v[0]}, 32'd0);
    tick();
    chk("single_tx_high_1cyc", {31'b0, tx_v[0]}, 32'd1);
    tick();
    check_frame(0, 'hA5, 8, 0, 1, 0);
    chk("single_idle_tx", {31'b0, tx_v[0]}, 32'd1);
    chk("single_idle_busy", {31'b0, busy_v[0]}, 32'd0);
    check_idle(0, 5);

    // random single words
    for (int i = 0; i < 3; i++) begin
      w = $urandom_range(0, 255);
      push_word(0, 9'(w));
      wait_start(0);
      check_frame(0, w, 8, 0, 1, 0);
      check_idle(0, 3);
    end

    // back-to-back: fixed then random triples, no idle gap between frames
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        w = (r == 0) ? i + 1 : int'($urandom_range(0, 255));
        q.push_back(w);
        push_word(0, 9'(w));
      end
      wait_start(0);
      while (q.size() > 0) begin
        w = q.pop_front();
        check_frame(0, w, 8, 0, 1, q.size());
      end
      check_idle(0, 4);
    end

    // parity: 7E1 and 7O1 with 0x07, then random words
    push_word(1, 9'h007);
    wait_start(1);
    check_frame(1, 'h07, 7, 2, 1, 0);
    push_word(2, 9'h007);
    wait_start(2);
    check_frame(2, 'h07, 7, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      w = $urandom_range(0, 127);
      push_word(1, 9'(w));
      wait_start(1);
      check_frame(1, w, 7, 2, 1, 0);
      w = $urandom_range(0, 127);
      push_word(2, 9'(w));
      wait_start(2);
      check_frame(2, w, 7, 1, 1, 0);
    end
    check_idle(1, 3);

    // two stop bits: 0x00 then a random word queued right behind it
    w = $urandom_range(0, 255);
    push_word(3, 9'h000);
    push_word(3, 9'(w));
    wait_start(3);
    check_frame(3, 'h00, 8, 0, 2, 1);
    check_frame(3, w, 8, 0, 2, 0);
    check_idle(3, 5);

    // overflow: DEPTH=4, six pushes while the line is busy
    push_word(0, 9'h03C);
    tick(); tick();
    chk("ovf_pre_error", {31'b0, err_v[0]}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(0, 255);
      if (i < 4) q.push_back(w);
      push_word(0, 9'(w));
    end
    chk("ovf_full", {31'b0, full_v[0]}, 32'd1);
    chk("ovf_level", {27'b0, lvl_v[0]}, 32'd4);
    chk("ovf_error", {31'b0, err_v[0]}, 32'd1);
    for (int i = 0; i < 10 * DIV - 6; i++) tick();
    while (q.size() > 0) begin
      w = q.pop_front();
      check_frame(0, w, 8, 0, 1, q.size());
    end
    check_idle(0, 40);
    chk("ovf_error_sticky", {31'b0, err_v[0]}, 32'd1);

    // reset in data bit 3 of 0xFF with two words queued
    push_word(0, 9'h0FF);
    tick(); tick();
    push_word(0, 9'(int'($urandom_range(0, 255))));
    push_word(0, 9'(int'($urandom_range(0, 255))));
    for (int i = 0; i < 48; i++) tick();
    chk("mid_tx_bit3", {31'b0, tx_v[0]}, 32'd1);
    chk("mid_level", {27'b0, lvl_v[0]}, 32'd2);
    rst  = 1'b0;
    din0 = 8'h55;
    push[0] = 1'b1;
    tick();
    chk("rstmid_tx", {31'b0, tx_v[0]}, 32'd1);
    chk("rstmid_busy", {31'b0, busy_v[0]}, 32'd0);
    chk("rstmid_level", {27'b0, lvl_v[0]}, 32'd0);
    chk("rstmid_empty", {31'b0, empty_v[0]}, 32'd1);
    chk("rstmid_full", {31'b0, full_v[0]}, 32'd0);
    chk("rstmid_error", {31'b0, err_v[0]}, 32'd0);
    tick();
    chk("rst_push_ignored", {27'b0, lvl_v[0]}, 32'd0);
    rst = 1'b1;
    push[0] = 1'b0;
    tick();
    chk("post_rst_level", {27'b0, lvl_v[0]}, 32'd0);
    chk("post_rst_empty", {31'b0, empty_v[0]}, 32'd1);
    check_idle(0, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
